// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } state_e;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int         DEF_TIMEOUT   = 50000;
  localparam int         WORD_BYTES    = 4;

  // A frame is in progress in any state between the sync byte and the last write.
  function automatic logic in_frame(input state_e s);
    return (s == LEN) || (s == DATA) || (s == WRITE);
  endfunction

endpackage

// File: rtl/imem_loader_timer.sv
// Inter-byte idle counter: expires after TIMEOUT consecutive enabled cycles without a clear.
module imem_loader_timer #(
  parameter int TIMEOUT = 50000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int             CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is flagged during the cycle whose closing edge is the TIMEOUT-th idle edge.
  assign expire_o = en_i && (cnt_q >= LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: assembles little-endian words from a UART byte stream,
// writes them into instruction memory and holds the core in reset while loading.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         DEPTH     = 20,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int         TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [31:0] pc,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        core_hold,
  output logic        busy,
  output logic        error,
  output logic [4:0]  words_loaded
);

  localparam int         CW      = 5;
  localparam int         BW      = $clog2(WORD_BYTES);
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);
  localparam logic [BW-1:0] LAST_LANE = BW'(WORD_BYTES - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  n_q, n_d;
  logic [CW-1:0]  widx_q, widx_d;
  logic [CW-1:0]  words_q, words_d;
  logic [BW-1:0]  bidx_q, bidx_d;
  logic [31:0]    word_q, word_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wd_q, wd_d;
  logic           we_q, hold_q, busy_q, err_q;
  logic           sync_hit;
  logic           expire;

  assign sync_hit = rx_valid && (rx_data == SYNC_BYTE);

  imem_loader_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clear_i  (rx_valid || !in_frame(state_q)),
    .en_i     (in_frame(state_q)),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    widx_d  = widx_q;
    words_d = words_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (sync_hit) state_d = LEN;
      end
      LEN: begin
        if (rx_valid) begin
          if ((rx_data == 8'd0) || (rx_data > DEPTH_B)) begin
            state_d = ERR;
          end else begin
            n_d     = rx_data[CW-1:0];
            widx_d  = '0;
            bidx_d  = '0;
            state_d = DATA;
          end
        end else if (expire) begin
          state_d = ERR;
        end
      end
      DATA: begin
        if (rx_valid) begin
          word_d[8*bidx_q +: 8] = rx_data;
          bidx_d = bidx_q + 1'b1;
          if (bidx_q == LAST_LANE) begin
            wd_d    = word_d;
            addr_d  = {25'd0, widx_q, 2'b00};
            state_d = WRITE;
          end
        end else if (expire) begin
          state_d = ERR;
        end
      end
      WRITE: begin
        widx_d = widx_q + 1'b1;
        // A byte arriving alongside the write already belongs to the next word.
        if (rx_valid) begin
          word_d[7:0] = rx_data;
          bidx_d      = BW'(1);
        end
        if ((widx_q + 1'b1) == n_q) begin
          words_d = n_q;
          state_d = IDLE;
        end else if (!rx_valid && expire) begin
          state_d = ERR;
        end else begin
          state_d = DATA;
        end
      end
      ERR: begin
        if (sync_hit) state_d = LEN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      n_q     <= '0;
      widx_q  <= '0;
      words_q <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      words_q <= words_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      we_q    <= (state_d == WRITE);
      hold_q  <= (state_d != IDLE);
      busy_q  <= in_frame(state_d);
      err_q   <= (state_d == ERR);
    end
  end

  assign imem_we      = we_q;
  assign imem_wd      = wd_q;
  assign imem_addr    = (state_q == IDLE) ? pc : addr_q;
  assign core_hold    = hold_q;
  assign busy         = busy_q;
  assign error        = err_q;
  assign words_loaded = words_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Serial program loader and access sequencer for the core's 20-word instruction memory. It consumes a byte stream from the UART receiver and assembles little-endian 32-bit words. It drives the memory's write port (write enable, address, write data) and holds the core in reset while programming. Outside a load it passes the core PC straight through to the memory address port.

## Interface
Parameters:
- DEPTH, 20: instruction memory depth in words; also the maximum legal word count.
- SYNC_BYTE, 8'hA5: byte that opens a load frame.
- TIMEOUT, 50000: maximum idle cycles allowed between bytes inside a frame.

Ports:
- CLK  in  1  single system clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- rx_data  in  8  received UART byte.
- pc  in  32  core program counter.
- imem_we  out  1  memory write enable.
- imem_addr  out  32  memory byte address.
- imem_wd  out  32  memory write data.
- core_hold  out  1  holds the core in reset while high.
- busy  out  1  a frame is in progress.
- error  out  1  the last frame was aborted.
- words_loaded  out  5  word count of the last completed frame.

## Operation
- Frame format: SYNC_BYTE, then a count byte N (1..DEPTH), then 4·N data bytes. Byte k of each word lands in bits [8k+7:8k], so the least-significant byte comes first.
- States:
  - IDLE
    - core_hold=0 and imem_addr=pc.
    - rx_valid with SYNC_BYTE goes to LEN. All other bytes are ignored.
  - LEN
    - If N==0 or N>DEPTH, go to ERR.
    - Otherwise latch N, clear the word index (widx) and byte index (bidx), and go to DATA.
  - DATA
    - Each rx_valid shifts the byte into lane bidx, then bidx++.
    - On the 4th byte, go to WRITE.
    - SYNC_BYTE here is ordinary data, not a resync.
  - WRITE
    - For exactly one cycle: imem_we=1, imem_addr={widx,2'b00}, imem_wd=assembled word.
    - Then widx++.
    - If widx+1==N, go to IDLE and load words_loaded=N. Otherwise return to DATA.
    - A byte strobed during WRITE is captured as lane 0 of the next word and is not lost.
  - ERR
    - core_hold=1 and error=1.
    - A SYNC_BYTE strobe goes to LEN and clears error. Other bytes are ignored.
- Timeout: in LEN, DATA or WRITE, TIMEOUT consecutive cycles without rx_valid go to ERR. The counter restarts on every rx_valid.
- Output derivation:
  - busy = state ∈ {LEN, DATA, WRITE}.
  - core_hold = state ≠ IDLE.
  - imem_addr = pc in IDLE; otherwise the registered loader address.
- Writes issue in address order 0..N-1. Words ≥N are not touched.
- Reset values: state IDLE, imem_we=0, imem_wd=0, loader address 0, core_hold=0, busy=0, error=0, words_loaded=0, and all counters 0.
- Reset in the middle of a frame: return to IDLE immediately. Words already written stay in memory. No further write is issued.

## Timing
- Frame progression:
  - SYNC accepted at edge t: core_hold and busy are high from cycle t+1.
  - 4th byte of a word at edge t: imem_we is high during cycle t+1 only.
  - Last WRITE cycle at t: core_hold=0, busy=0 and the words_loaded update are all visible at t+1. The core leaves reset with the new program and PC at 0.
- Timeout: the last byte at edge t with no further rx_valid enters ERR at edge t+TIMEOUT.
- Output sourcing:
  - imem_we, imem_wd, core_hold, busy and error are registered.
  - imem_addr is a combinational mux of pc and the loader address register.
- No back-pressure. One byte per cycle is tolerated at most, because WRITE accepts bytes.

## Structure
- Package imem_loader_pkg holds:
  - the state enum (IDLE, LEN, DATA, WRITE, ERR);
  - the default SYNC_BYTE and TIMEOUT;
  - the WORD_BYTES=4 constant.
- One sub-module, imem_loader_timer: the inter-byte timeout counter. It has clear/enable inputs and an expire output, and is sized to $clog2(TIMEOUT+1).

## Test plan
- Basic load:
  - Stimulus: A5, 02, 13 00 00 00, 93 00 10 00.
  - Required: imem_we pulses at addr 0 with wd 0x00000013, then at addr 4 with wd 0x00100093. words_loaded=2, core_hold falls, and imem_addr follows pc afterwards.
- Bad count:
  - A5, 15 (N=21) → ERR, error=1, core_hold=1, no writes.
  - A5, 00 → ERR, error=1, core_hold=1, no writes.
- Stall timeout:
  - Stimulus: A5, 01, 13 00, then silence.
  - Required: error=1 exactly TIMEOUT cycles after the last byte, with no write.
  - Then A5, 01, 4 bytes recovers: error clears and one write is issued.
- SYNC_BYTE inside data:
  - Stimulus: A5, 01, A5 A5 A5 A5.
  - Required: one write of 0xA5A5A5A5 at addr 0.
- Back-to-back bytes: the first byte of word 1 is strobed during the WRITE cycle of word 0. Both words must be written correctly.
- Reset during a frame:
  - Stimulus: RST after the first word's write of an N=3 frame.
  - Required: state IDLE, core_hold=0 the next cycle, no further writes, words_loaded unchanged.
